seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider for the ALU datapath.
- Computes quotient and remainder of two BITS-wide operands using one shift/trial-subtract step per clock.
- Serves the DIV/MOD operations that the combinational adder/subtractor path cannot cover in one cycle.
- Uses a start/done handshake; the control unit stalls on busy_o.

Parameters:
- BITS, 8, operand, quotient and remainder width (≥2).

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request a division; sampled only in IDLE or DONE.
- dividend_i  input  BITS  unsigned dividend; captured on the accepting edge.
- divisor_i  input  BITS  unsigned divisor; captured on the accepting edge.
- busy_o  output  1  high while in DIVIDE.
- done_o  output  1  one-cycle pulse; quotient_o and remainder_o are valid.
- quotient_o  output  BITS  unsigned quotient.
- remainder_o  output  BITS  unsigned remainder.
- flag_z_o  output  1  divide-by-zero flag for the current result.

Behaviour:
- States:
  - IDLE
  - DIVIDE
  - DONE
- Reset (rst_i high at an edge):
  - state goes to IDLE; iteration counter is cleared.
  - busy_o=0, done_o=0, quotient_o=0, remainder_o=0, flag_z_o=0.
  - Reset overrides start_i and aborts any in-flight division with no done_o pulse.
- IDLE/DONE, start_i=1, divisor_i≠0 (acceptance edge t):
  - Latch the operands into the internal dividend/divisor registers.
  - Clear the partial remainder (BITS+1 bits wide), clear flag_z_o, load counter=BITS, go to DIVIDE.
- IDLE/DONE, start_i=1, divisor_i=0:
  - Go directly to DONE.
  - quotient_o = all ones, remainder_o = dividend_i, flag_z_o=1.
  - done_o high in the cycle after edge t, i.e. latency 1.
- IDLE/DONE, start_i=0:
  - DONE goes to IDLE; IDLE stays in IDLE.
  - quotient_o, remainder_o and flag_z_o hold their last values.
- DIVIDE, each edge, one iteration:
  - Shift {partial remainder, dividend register} left by 1.
  - trial = partial remainder − divisor, computed BITS+1 wide.
  - If trial is non-negative (MSB=0): partial remainder ← trial, and shift 1 into the quotient LSB. Otherwise keep the partial remainder and shift in 0.
  - Decrement the counter.
  - When the counter reaches 1 at an edge, that edge performs the last iteration and moves to DONE.
- Latency:
  - Exactly BITS iterations at edges t+1 … t+BITS.
  - done_o is high for exactly one cycle, following edge t+BITS.
  - busy_o is high for BITS cycles, from after edge t to edge t+BITS.
- Outputs:
  - quotient_o and remainder_o update only on the transition into DONE.
  - In DONE they are stable; they remain held afterwards until the next transition into DONE or a reset.
  - During DIVIDE they show the previous result.
- start_i while in DIVIDE is ignored; no queuing, and the in-flight operation is unaffected.
- Back-to-back: start_i high during DONE is accepted on that edge, so a new division follows with zero idle cycles; done_o still pulses only once per operation.
- Arithmetic:
  - Unsigned only. Sign handling is done outside this block.
  - Invariant: dividend = quotient·divisor + remainder, with remainder < divisor (divisor≠0).
- Operand inputs may change freely after the acceptance edge.

Test Plan (BITS=8):
- Reset, then start with 100/7 → busy_o for 8 cycles; done_o one cycle after edge t+8; quotient_o=14, remainder_o=2, flag_z_o=0.
- 255/1 and 3/10 in turn → (255, 0) and (0, 3).
- 5/0 → done_o one cycle after acceptance; quotient_o=0xFF, remainder_o=5, flag_z_o=1. A following 9/3 clears the flag: (3, 0).
- Start 200/9, then pulse start_i with 50/5 at cycle 3 of DIVIDE → ignored; result (22, 2), single done_o pulse.
- Start 200/9, assert rst_i at cycle 4 → next cycle all outputs 0, state IDLE, no done_o. A fresh 17/4 then gives (4, 1).
- Hold start_i high across DONE with 60/6 then 61/6 → second operation accepted in the DONE cycle. Results (10, 0) then (10, 1), done_o pulses 9 cycles apart.
- Randomized: 1000 random pairs vs. a reference model of / and %, plus a divisor≠0 invariant check.

Source files
------------

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
// Divide-by-zero short-circuits to DONE with quotient all ones and remainder = dividend.
module seq_divider #(
  parameter int BITS = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [BITS-1:0] dividend_i,
  input  logic [BITS-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [BITS-1:0] quotient_o,
  output logic [BITS-1:0] remainder_o,
  output logic            flag_z_o
);

  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t          state;
  logic [BITS-1:0] dvd;
  logic [BITS-1:0] dvs;
  logic [BITS-1:0] prem;
  logic [CW-1:0]   cnt;

  logic [BITS:0]   shifted;
  logic [BITS:0]   trial;
  logic [BITS-1:0] prem_nxt;
  logic [BITS-1:0] dvd_nxt;

  // prem < dvs always holds, so the shifted remainder fits BITS+1 bits and
  // trial[BITS] is a reliable borrow.
  always_comb begin
    shifted  = {prem, dvd[BITS-1]};
    trial    = shifted - {1'b0, dvs};
    prem_nxt = shifted[BITS-1:0];
    dvd_nxt  = {dvd[BITS-2:0], 1'b0};
    if (!trial[BITS]) begin
      prem_nxt = trial[BITS-1:0];
      dvd_nxt  = {dvd[BITS-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      flag_z_o    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            if (divisor_i != '0) begin
              dvd      <= dividend_i;
              dvs      <= divisor_i;
              prem     <= '0;
              flag_z_o <= 1'b0;
              cnt      <= CW'(BITS);
              busy_o   <= 1'b1;
              state    <= DIVIDE;
            end else begin
              quotient_o  <= '1;
              remainder_o <= dividend_i;
              flag_z_o    <= 1'b1;
              done_o      <= 1'b1;
              state       <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
        DIVIDE: begin
          dvd  <= dvd_nxt;
          prem <= prem_nxt;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            quotient_o  <= dvd_nxt;
            remainder_o <= prem_nxt;
            state       <= DONE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider against a / and % reference
module tb_seq_divider;
  localparam int BITS = 8;
  localparam int MAXV = (1 << BITS) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [BITS-1:0] dividend = '0;
  logic [BITS-1:0] divisor = '0;
  logic            busy;
  logic            done;
  logic            flag_z;
  logic [BITS-1:0] quotient;
  logic [BITS-1:0] remainder;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_run = 0;
  int last_q = 0;
  int last_r = 0;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    bit z;
    int done_cyc;
    int busy_len;
  } exp_t;

  exp_t sbq[$];

  seq_divider #(.BITS(BITS)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .dividend_i(dividend),
    .divisor_i(divisor),
    .busy_o(busy),
    .done_o(done),
    .quotient_o(quotient),
    .remainder_o(remainder),
    .flag_z_o(flag_z)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(int a, int b, int t);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = MAXV; e.r = a; e.z = 1'b1; e.done_cyc = t; e.busy_len = 0;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0; e.done_cyc = t + BITS; e.busy_len = BITS;
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever done is seen
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_run = 0; last_q = 0; last_r = 0;
      end else begin
        if (busy) begin
          busy_run++;
          check("hold_q", int'(quotient), last_q);
          check("hold_r", int'(remainder), last_r);
        end
        if (done) begin
          if (sbq.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sbq.pop_front();
            check("quotient", int'(quotient), e.q);
            check("remainder", int'(remainder), e.r);
            check("flag_z", int'(flag_z), int'(e.z));
            check("done_cycle", cyc, e.done_cyc);
            check("busy_len", busy_run, e.busy_len);
            if (!e.z) begin
              check("invariant", int'(quotient) * e.b + int'(remainder), e.a);
              check("rem_lt_div", int'(int'(remainder) < e.b), 1);
            end
            last_q = e.q;
            last_r = e.r;
          end
          busy_run = 0;
        end
      end
    end
  end

  task automatic issue(int a, int b);
    start    = 1'b1;
    dividend = BITS'(a);
    divisor  = BITS'(b);
    sbq.push_back(model(a, b, cyc + 1));
  endtask

  task automatic wait_drain(int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sbq.size() != 0) begin
      check("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic run(int a, int b);
    @(negedge clk);
    issue(a, b);
    @(negedge clk);
    start = 1'b0;
    wait_drain(4 * BITS);
  endtask

  task automatic check_cleared(string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_q"}, int'(quotient), 0);
    check({tag, "_r"}, int'(remainder), 0);
    check({tag, "_z"}, int'(flag_z), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    int n;
    int a;
    int b;

    repeat (3) @(negedge clk);
    #1;
    check_cleared("reset");
    rst = 1'b0;

    run(100, 7);
    run(255, 1);
    run(3, 10);
    run(5, 0);
    run(9, 3);

    // start during DIVIDE must be ignored
    @(negedge clk);
    issue(200, 9);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_drain(4 * BITS);
    repeat (BITS + 2) @(negedge clk);

    // reset aborts an in-flight division
    @(negedge clk);
    issue(200, 9);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_cleared("abort");
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (BITS + 2) @(negedge clk);
    run(17, 4);

    // back-to-back: start held through DONE
    @(negedge clk);
    t0 = cyc + 1;
    issue(60, 6);
    @(negedge clk);
    dividend = 8'd61;
    sbq.push_back(model(61, 6, t0 + BITS + 1));
    n = 0;
    while (cyc < t0 + BITS + 1 && n < 4 * BITS) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    wait_drain(4 * BITS);

    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, MAXV));
      if ($urandom_range(0, 15) == 0) b = 0;
      else if ($urandom_range(0, 3) == 0) b = int'($urandom_range(1, 15));
      else b = int'($urandom_range(1, MAXV));
      run(a, b);
    end

    repeat (BITS + 4) @(negedge clk);
    check("queue_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
